counter_5b_sequencer: RTL and testbench

- Controller that drives a counter_5b instance through programmed triangle sweeps: clear, count up to hi_limit, count down to lo_limit, repeat N times.
- Drives the counter's enable, up_down and reset, and watches its count output.
- Sits between a host (start/busy/done handshake) and the counter datapath.
- Supports pause and abort.

---
 rtl/counter_seq_pkg.sv | 17 +
 rtl/counter_5b.sv | 20 ++
 rtl/counter_seq_dwell_timer.sv | 27 ++
 rtl/counter_5b_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_counter_5b_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and default sizes for the counter_5b triangle-sweep sequencer.
package counter_seq_pkg;

  localparam int W_DEF            = 5;
  localparam int NS_DEF           = 4;
  localparam int DWELL_CYCLES_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    UP,
    DOWN,
    DONE,
    DWELL
  } state_t;

endpackage

// File: rtl/counter_5b.sv
// Up/down counter driven by the sequencer; holds when enable is low.
module counter_5b #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         up_down,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= up_down ? count + W'(1) : count - W'(1);
    end
  end

endmodule

// File: rtl/counter_seq_dwell_timer.sv
// Loadable down-counter with a zero flag; times the hold at each sweep turning point.
module counter_seq_dwell_timer #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          hold,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!hold && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/counter_5b_sequencer.sv
// Drives a counter through clear / up to hi / down to lo triangle sweeps, repeated N times.
// Define COUNTER_SEQ_DWELL_EN to add a timed hold at each turning point.
module counter_5b_sequencer
  import counter_seq_pkg::*;
#(
  parameter int W            = W_DEF,
  parameter int NS           = NS_DEF,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          pause,
  input  logic [W-1:0]  lo_limit,
  input  logic [W-1:0]  hi_limit,
  input  logic [NS-1:0] sweeps,
  input  logic [W-1:0]  cnt_value,
  output logic          cnt_enable,
  output logic          cnt_up_down,
  output logic          cnt_reset,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [NS-1:0] sweeps_left
);

  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("DWELL_CYCLES must be at least 1");
  end

  state_t       state, next_state;
  logic [W-1:0] lo_r, hi_r;
  logic         err_r;
  logic         at_hi, at_lo, last_sweep, start_ok;

  // Overshoot past a limit is treated as reaching it, so the counter never wraps.
  assign at_hi      = (cnt_value >= hi_r);
  assign at_lo      = (cnt_value <= lo_r);
  assign last_sweep = (sweeps_left == NS'(1));
  assign start_ok   = start && !abort;

`ifdef COUNTER_SEQ_DWELL_EN
  localparam int DCW = $clog2(DWELL_CYCLES + 1);
  logic dwell_load, dwell_zero, dwell_up;

  counter_seq_dwell_timer #(.CW(DCW)) u_dwell_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (dwell_load),
    .load_value (DCW'(DWELL_CYCLES - 1)),
    .hold       (pause),
    .zero       (dwell_zero)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      lo_r        <= '0;
      hi_r        <= '0;
      sweeps_left <= '0;
      err_r       <= 1'b0;
`ifdef COUNTER_SEQ_DWELL_EN
      dwell_up    <= 1'b0;
`endif
    end else begin
      state <= next_state;
      err_r <= 1'b0;
      if (state == IDLE) begin
        if (start_ok) begin
          lo_r <= lo_limit;
          hi_r <= hi_limit;
          if (lo_limit >= hi_limit) begin
            err_r       <= 1'b1;
            sweeps_left <= '0;
          end else begin
            sweeps_left <= sweeps;
          end
        end
      end else if (abort) begin
        sweeps_left <= '0;
      end else if (state == DOWN && !pause && at_lo) begin
        sweeps_left <= sweeps_left - NS'(1);
      end
`ifdef COUNTER_SEQ_DWELL_EN
      if (dwell_load) dwell_up <= (state == DOWN);
`endif
    end
  end

  always_comb begin
    next_state = state;
`ifdef COUNTER_SEQ_DWELL_EN
    dwell_load = 1'b0;
`endif
    if (state != IDLE && abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok && lo_limit < hi_limit)
            next_state = (sweeps == '0) ? DONE : CLEAR;
        end
        CLEAR: next_state = UP;
        UP: begin
          if (!pause && at_hi) begin
`ifdef COUNTER_SEQ_DWELL_EN
            next_state = DWELL;
            dwell_load = 1'b1;
`else
            next_state = DOWN;
`endif
          end
        end
        DOWN: begin
          if (!pause && at_lo) begin
            if (last_sweep) begin
              next_state = DONE;
            end else begin
`ifdef COUNTER_SEQ_DWELL_EN
              next_state = DWELL;
              dwell_load = 1'b1;
`else
              next_state = UP;
`endif
            end
          end
        end
        DONE: next_state = IDLE;
`ifdef COUNTER_SEQ_DWELL_EN
        DWELL: begin
          if (!pause && dwell_zero) next_state = dwell_up ? UP : DOWN;
        end
`endif
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_enable  = 1'b0;
    cnt_up_down = 1'b0;
    cnt_reset   = 1'b0;
    busy        = (state == CLEAR) || (state == UP) || (state == DOWN) || (state == DWELL);
    done        = (state == DONE) && !abort;
    err         = err_r;
    if (state != IDLE && abort) begin
      cnt_reset = 1'b1;
    end else begin
      case (state)
        CLEAR: cnt_reset = 1'b1;
        UP: begin
          if (!pause) begin
`ifdef COUNTER_SEQ_DWELL_EN
            cnt_enable  = !at_hi;
            cnt_up_down = 1'b1;
`else
            cnt_enable  = 1'b1;
            cnt_up_down = !at_hi;
`endif
          end
        end
        DOWN: begin
          if (!pause) begin
            if (!at_lo) begin
              cnt_enable = 1'b1;
            end else if (!last_sweep) begin
`ifndef COUNTER_SEQ_DWELL_EN
              cnt_enable  = 1'b1;
              cnt_up_down = 1'b1;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_5b_sequencer.sv
// Scoreboard bench: counter_5b driven by counter_5b_sequencer through directed sweep scenarios.
module tb_counter_5b_sequencer;

  localparam int W  = 5;
  localparam int NS = 4;

  logic          clock = 1'b0;
  logic          reset, start, abort, pause;
  logic [W-1:0]  lo_limit, hi_limit, cnt_value;
  logic [NS-1:0] sweeps, sweeps_left;
  logic          cnt_enable, cnt_up_down, cnt_reset, busy, done, err;

  always #5 clock = ~clock;

  counter_5b_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .pause       (pause),
    .lo_limit    (lo_limit),
    .hi_limit    (hi_limit),
    .sweeps      (sweeps),
    .cnt_value   (cnt_value),
    .cnt_enable  (cnt_enable),
    .cnt_up_down (cnt_up_down),
    .cnt_reset   (cnt_reset),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sweeps_left (sweeps_left)
  );

  counter_5b #(.W(W)) u_cnt (
    .clock   (clock),
    .reset   (reset | cnt_reset),
    .enable  (cnt_enable),
    .up_down (cnt_up_down),
    .count   (cnt_value)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // step = counter value and direction seen on each enabled cycle
  typedef struct { int val; int up; } step_t;
  // event kind = {done, err, cnt_reset}, with the cycle it must appear in
  typedef struct { int kind; int at; } ev_t;
  step_t step_q[$];
  ev_t   ev_q[$];
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_step(input int v, input int up);
    step_t s;
    s.val = v;
    s.up  = up;
    step_q.push_back(s);
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    ev_q.push_back(e);
  endtask

  // Expected counter trajectory of a complete n-sweep run.
  task automatic push_sweeps(input int lo, input int hi, input int n);
    for (int v = 0; v < hi; v++) push_step(v, 1);
    for (int s = 0; s < n; s++) begin
      push_step(hi, 0);
      for (int v = hi - 1; v > lo; v--) push_step(v, 0);
      if (s < n - 1) begin
        push_step(lo, 1);
        for (int v = lo + 1; v < hi; v++) push_step(v, 1);
      end
    end
  endtask

  // cnt_reset in CLEAR, then done after the full trajectory plus any paused cycles.
  task automatic push_run(input int lo, input int hi, input int n, input int c0, input int extra);
    push_sweeps(lo, hi, n);
    push_ev(1, c0 + 1);
    push_ev(4, c0 + 3 + hi + (2 * n - 1) * (hi - lo) + extra);
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_run(input int lo, input int hi, input int n, output int c0);
    lo_limit = W'(lo);
    hi_limit = W'(hi);
    sweeps   = NS'(n);
    start    = 1'b1;
    c0       = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  step_t ms;
  ev_t   me;
  int    mev;

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (cnt_enable) begin
        if (step_q.size() == 0) begin
          chk("step_extra", {cnt_up_down, cnt_value}, -1);
        end else begin
          ms = step_q.pop_front();
          chk("step_value", int'(cnt_value), ms.val);
          chk("step_dir", int'(cnt_up_down), ms.up);
        end
      end
      mev = {29'd0, done, err, cnt_reset};
      if (mev != 0) begin
        if (ev_q.size() == 0) begin
          chk("event_extra", mev, 0);
        end else begin
          me = ev_q.pop_front();
          chk("event_kind", mev, me.kind);
          chk("event_cycle", cyc, me.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    lo_limit = '0; hi_limit = '0; sweeps = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_outputs", {cnt_enable, cnt_up_down, cnt_reset, busy, done, err}, 0);
    chk("rst_sweeps_left", int'(sweeps_left), 0);
    chk("rst_cnt_value", int'(cnt_value), 0);
    mon_en = 1'b1;

    // Basic single sweep
    tick_to(cyc + 2);
    start_run(2, 5, 1, c0);
    push_run(2, 5, 1, c0, 0);
    tick_to(c0 + 3);
    chk("basic_busy", int'(busy), 1);
    tick_to(c0 + 11);
    chk("basic_done", int'(done), 1);
    tick_to(c0 + 12);
    chk("basic_hold_lo", int'(cnt_value), 2);
    chk("basic_busy_after", int'(busy), 0);

    // Two full-range sweeps
    tick_to(cyc + 2);
    start_run(0, 31, 2, c0);
    push_run(0, 31, 2, c0, 0);
    tick_to(c0 + 1);
    chk("rep_left_2", int'(sweeps_left), 2);
    tick_to(c0 + 64);
    chk("rep_left_2b", int'(sweeps_left), 2);
    tick_to(c0 + 65);
    chk("rep_left_1", int'(sweeps_left), 1);
    tick_to(c0 + 127);
    chk("rep_left_0", int'(sweeps_left), 0);
    tick_to(c0 + 128);
    chk("rep_hold_lo", int'(cnt_value), 0);

    // Rejected start: lo == hi
    tick_to(cyc + 2);
    start_run(7, 7, 1, c0);
    push_ev(2, c0 + 1);
    tick_to(c0 + 1);
    chk("rej_err", int'(err), 1);
    chk("rej_busy", int'(busy), 0);
    tick_to(c0 + 2);
    chk("rej_err_clear", int'(err), 0);

    // Pause for 4 cycles at count 10 on the way up
    tick_to(cyc + 2);
    start_run(2, 12, 1, c0);
    push_run(2, 12, 1, c0, 4);
    tick_to(c0 + 12);
    pause = 1'b1;
    tick_to(c0 + 15);
    chk("pause_held", int'(cnt_value), 10);
    chk("pause_enable", int'(cnt_enable), 0);
    tick_to(c0 + 16);
    pause = 1'b0;
    tick_to(c0 + 30);

    // Abort at count 20
    tick_to(cyc + 2);
    start_run(1, 25, 1, c0);
    for (int v = 0; v < 20; v++) push_step(v, 1);
    push_ev(1, c0 + 1);
    push_ev(1, c0 + 22);
    tick_to(c0 + 22);
    abort = 1'b1;
    tick_to(c0 + 23);
    abort = 1'b0;
    chk("abort_cnt", int'(cnt_value), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_left", int'(sweeps_left), 0);
    tick_to(c0 + 30);

    // Reset mid-run, then a fresh basic run
    tick_to(cyc + 2);
    start_run(2, 5, 1, c0);
    for (int v = 0; v < 3; v++) push_step(v, 1);
    push_ev(1, c0 + 1);
    tick_to(c0 + 5);
    reset = 1'b1;
    tick_to(c0 + 6);
    reset = 1'b0;
    chk("mid_rst_outputs", {cnt_enable, cnt_up_down, cnt_reset, busy, done, err}, 0);
    chk("mid_rst_left", int'(sweeps_left), 0);
    chk("mid_rst_cnt", int'(cnt_value), 0);
    tick_to(cyc + 2);
    start_run(2, 5, 1, c0);
    push_run(2, 5, 1, c0, 0);
    tick_to(c0 + 13);
    chk("rerun_hold_lo", int'(cnt_value), 2);
    chk("rerun_busy", int'(busy), 0);

    tick_to(cyc + 3);
    chk("steps_consumed", step_q.size(), 0);
    chk("events_consumed", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
